// File: rtl/irq_pending_arbiter.sv
// Sticky pending capture of 8 request lines with masked highest-index-first grant.
// Latency: event edge t -> pending after t -> out_valid after t+1; one idle bubble per grant.
// Backpressure: offer holds out_idx until out_ready; pending keeps collecting events meanwhile.
module irq_pending_arbiter #(
  parameter int N_REQ     = 8,
  parameter int IDX_W     = 3,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_in,
  input  logic [N_REQ-1:0] mask,
  input  logic             clr_all,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N_REQ-1:0] pending,
  output logic             lost_evt
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t           state;
  logic [N_REQ-1:0] req_prev;
  logic [N_REQ-1:0] evt;
  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] served;
  logic [N_REQ-1:0] lost_hit;
  logic [IDX_W-1:0] winner;
  logic             hs;

  always_comb begin
    evt    = EDGE_MODE ? (req_in & ~req_prev) : req_in;
    cand   = pending & mask;
    winner = '0;
    // Ascending scan: the last hit is the highest index, which has priority.
    for (int i = 0; i < N_REQ; i++) begin
      if (cand[i]) winner = IDX_W'(i);
    end
    hs     = out_valid & out_ready;
    served = '0;
    if (hs) served[out_idx] = 1'b1;
    // A bit being served on this edge is free to take a new event without loss.
    lost_hit = EDGE_MODE ? (evt & pending & ~served) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_prev  <= '0;
      pending   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      lost_evt  <= 1'b0;
    end else begin
      // Track the lines even while flushing so a held line does not re-fire.
      req_prev <= req_in;
      if (clr_all) begin
        pending   <= '0;
        lost_evt  <= 1'b0;
        out_valid <= 1'b0;
        state     <= IDLE;
      end else begin
        pending <= (pending & ~served) | evt;
        if (|lost_hit) lost_evt <= 1'b1;
        case (state)
          IDLE: begin
            if (|cand) begin
              out_idx   <= winner;
              out_valid <= 1'b1;
              state     <= OFFER;
            end
          end
          OFFER: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
          default: begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Directed scenarios plus randomized traffic checked against a cycle model of the arbiter rules.
module tb_irq_pending_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_in = '0;
  logic [7:0] mask = 8'hFF;
  logic       clr_all = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] pending;
  logic       lost_evt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  bit [7:0] m_pend;
  bit [7:0] m_prev;
  bit       m_valid;
  int       m_idx;
  bit       m_lost;

  irq_pending_arbiter #(.N_REQ(8), .IDX_W(3), .EDGE_MODE(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .mask     (mask),
    .clr_all  (clr_all),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_idx  (out_idx),
    .pending  (pending),
    .lost_evt (lost_evt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pend = '0; m_prev = '0; m_valid = 1'b0; m_idx = 0; m_lost = 1'b0;
  endtask

  // Applies the arbiter rules to the inputs present at the coming edge.
  task automatic model_step();
    bit [7:0] nxt;
    bit       hs;
    int       best;
    if (clr_all) begin
      m_pend = '0; m_lost = 1'b0; m_valid = 1'b0;
      m_prev = req_in;
      return;
    end
    hs  = m_valid && out_ready;
    nxt = m_pend;
    for (int i = 0; i < 8; i++) begin
      bit rise;
      rise = req_in[i] && !m_prev[i];
      if (rise) begin
        if (m_pend[i] && !(hs && i == m_idx)) m_lost = 1'b1;
        nxt[i] = 1'b1;
      end else if (hs && i == m_idx) begin
        nxt[i] = 1'b0;
      end
    end
    if (!m_valid) begin
      best = -1;
      for (int i = 7; i >= 0; i--) begin
        if (best < 0 && m_pend[i] && mask[i]) best = i;
      end
      if (best >= 0) begin
        m_valid = 1'b1;
        m_idx   = best;
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    m_pend = nxt;
    m_prev = req_in;
  endtask

  task automatic tick();
    if (rst_n) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({out_valid, out_idx, pending, lost_evt} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b idx=%0d pend=%h lost=%b, want all 0",
               out_valid, out_idx, pending, lost_evt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic test_single_pulse();
    req_in = 8'h20; tick();
    req_in = 8'h00; tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd5) begin
      n_fail++;
      $display("FAIL single_offer: got valid=%b idx=%0d, want valid=1 idx=5", out_valid, out_idx);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      n_fail++;
      $display("FAIL single_done: got valid=%b pend=%h, want valid=0 pend=00", out_valid, pending);
    end
  endtask

  task automatic test_priority_pair();
    req_in = 8'h44; tick();
    req_in = 8'h00; tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd6) begin
      n_fail++;
      $display("FAIL pair_first: got valid=%b idx=%0d, want valid=1 idx=6", out_valid, out_idx);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || pending !== 8'h04) begin
      n_fail++;
      $display("FAIL pair_bubble: got valid=%b pend=%h, want valid=0 pend=04", out_valid, pending);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd2) begin
      n_fail++;
      $display("FAIL pair_second: got valid=%b idx=%0d, want valid=1 idx=2", out_valid, out_idx);
    end
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      n_fail++;
      $display("FAIL pair_drain: got valid=%b pend=%h, want valid=0 pend=00", out_valid, pending);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    req_in = 8'h08; tick();
    req_in = 8'h00; tick();
    for (int c = 0; c < 5; c++) begin
      req_in = (c == 1) ? 8'h80 : 8'h00;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_idx !== 3'd3) begin
        n_fail++;
        $display("FAIL hold_offer[%0d]: got valid=%b idx=%0d, want valid=1 idx=3", c, out_valid, out_idx);
      end
    end
    out_ready = 1'b1; tick();
    n_checks++;
    if (out_valid !== 1'b0 || pending !== 8'h80) begin
      n_fail++;
      $display("FAIL hold_release: got valid=%b pend=%h, want valid=0 pend=80", out_valid, pending);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd7) begin
      n_fail++;
      $display("FAIL hold_next: got valid=%b idx=%0d, want valid=1 idx=7", out_valid, out_idx);
    end
    tick();
  endtask

  task automatic test_mask();
    mask = 8'h0F;
    req_in = 8'h10; tick();
    req_in = 8'h00; tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0 || pending !== 8'h10) begin
      n_fail++;
      $display("FAIL masked_hold: got valid=%b pend=%h, want valid=0 pend=10", out_valid, pending);
    end
    mask = 8'hFF; tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd4) begin
      n_fail++;
      $display("FAIL unmask_grant: got valid=%b idx=%0d, want valid=1 idx=4", out_valid, out_idx);
    end
    tick();
  endtask

  task automatic test_lost_and_clear();
    mask = 8'h00;
    req_in = 8'h02; tick();
    req_in = 8'h00; tick();
    req_in = 8'h02; tick();
    n_checks++;
    if (lost_evt !== 1'b1 || pending !== 8'h02) begin
      n_fail++;
      $display("FAIL lost_set: got lost=%b pend=%h, want lost=1 pend=02", lost_evt, pending);
    end
    req_in = 8'h00; clr_all = 1'b1; tick();
    clr_all = 1'b0;
    n_checks++;
    if (lost_evt !== 1'b0 || pending !== 8'h00 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_all: got lost=%b pend=%h valid=%b, want 0/00/0", lost_evt, pending, out_valid);
    end
    mask = 8'hFF;
  endtask

  task automatic test_back_to_back();
    // Event landing on the handshake edge of the same bit must survive without loss.
    out_ready = 1'b0;
    req_in = 8'h02; tick();
    req_in = 8'h00; tick();
    req_in = 8'h02; out_ready = 1'b1; tick();
    n_checks++;
    if (out_valid !== 1'b0 || pending !== 8'h02 || lost_evt !== 1'b0) begin
      n_fail++;
      $display("FAIL set_wins: got valid=%b pend=%h lost=%b, want 0/02/0", out_valid, pending, lost_evt);
    end
    req_in = 8'h00; tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd1) begin
      n_fail++;
      $display("FAIL regrant: got valid=%b idx=%0d, want valid=1 idx=1", out_valid, out_idx);
    end
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    req_in = 8'h08; tick();
    req_in = 8'h01; tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({out_valid, out_idx, pending, lost_evt} !== 13'd0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b idx=%0d pend=%h lost=%b, want all 0",
               out_valid, out_idx, pending, lost_evt);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL held_line_grant: got valid=%b idx=%0d, want valid=1 idx=0", out_valid, out_idx);
    end
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      n_fail++;
      $display("FAIL held_line_once: got valid=%b pend=%h, want valid=0 pend=00", out_valid, pending);
    end
    req_in = 8'h00;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      req_in    = 8'($urandom);
      mask      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      out_ready = 1'($urandom_range(0, 1));
      clr_all   = ($urandom_range(0, 31) == 0);
      tick();
      n_checks++;
      if (out_valid !== m_valid || out_idx !== 3'(m_idx) || pending !== m_pend || lost_evt !== m_lost) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: got valid=%b idx=%0d pend=%h lost=%b, want valid=%b idx=%0d pend=%h lost=%b",
                   c, out_valid, out_idx, pending, lost_evt, m_valid, m_idx, m_pend, m_lost);
      end
    end
    clr_all = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_pulse();
    test_priority_pair();
    test_backpressure();
    test_mask();
    test_lost_and_clear();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
